// File: rtl/mobo_bus_arbiter_if.sv
// Bundle of the arbiter's requester ports and motherboard bus signals.
//
// Handshake (four-phase, per requester): a master raises cmd (01 read,
// 10 write) and holds it until it sees done=1 in its status word, then drops
// cmd to 00. The arbiter holds done (and read data) until the drop is seen,
// then clears the status. On the bus side the arbiter drives a nonzero
// mobo_ctrl until the bus answers with mobo_stat.done (bit1). It only issues
// while mobo_stat.busy (bit0) is low.
interface mobo_bus_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ*WORD_WIDTH-1:0] req_ctrl;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_stat;
  logic [WORD_WIDTH-1:0]         req_rdata;
  logic [WORD_WIDTH-1:0]         mobo_ctrl;
  logic [WORD_WIDTH-1:0]         mobo_stat;
  logic [WORD_WIDTH-1:0]         addr_out;
  logic [WORD_WIDTH-1:0]         mobodat_out;
  logic [WORD_WIDTH-1:0]         mobodat_in;

  // Arbiter side: serves the requesters, drives the bus.
  modport slave (
    input  req_ctrl, req_addr, req_wdata, mobo_stat, mobodat_in,
    output req_stat, req_rdata, mobo_ctrl, addr_out, mobodat_out
  );

  // Environment side: requesters and the bus target.
  modport master (
    output req_ctrl, req_addr, req_wdata, mobo_stat, mobodat_in,
    input  req_stat, req_rdata, mobo_ctrl, addr_out, mobodat_out
  );
endinterface

// File: rtl/mobo_bus_arbiter.sv
// Round-robin arbiter sharing one motherboard bus between NUM_REQ masters.
// One transfer at a time: grant, issue when the bus is idle, wait for done
// (or time out), then hold the response until the winner drops its cmd.
module mobo_bus_arbiter #(
  parameter int WORD_WIDTH  = 32,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  mobo_bus_arbiter_if.slave      bus,
  output logic [1:0]             state_o
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [GW-1:0]                 gnt_q, gnt_d;
  logic [GW-1:0]                 rr_q, rr_d;
  logic [1:0]                    cmd_q, cmd_d;
  logic [WORD_WIDTH-1:0]         addr_q, addr_d;
  logic [WORD_WIDTH-1:0]         wdata_q, wdata_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]         ctrl_q, ctrl_d;
  logic [WORD_WIDTH-1:0]         aout_q, aout_d;
  logic [WORD_WIDTH-1:0]         dout_q, dout_d;
  logic [NUM_REQ*WORD_WIDTH-1:0] stat_q, stat_d;
  logic [WORD_WIDTH-1:0]         rdata_q, rdata_d;

  logic                          found;
  logic [GW-1:0]                 win;
  int                            idx;

  assign bus.mobo_ctrl   = ctrl_q;
  assign bus.addr_out    = aout_q;
  assign bus.mobodat_out = dout_q;
  assign bus.req_stat    = stat_q;
  assign bus.req_rdata   = rdata_q;
  assign state_o         = state_q;

  // Round-robin scan starting just after the last winner; a cmd is a valid
  // request only when exactly one of its two bits is set (01 or 10).
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && (bus.req_ctrl[idx*WORD_WIDTH] ^ bus.req_ctrl[idx*WORD_WIDTH+1])) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    aout_d  = aout_q;
    dout_d  = dout_q;
    stat_d  = stat_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = win;
          rr_d    = win;
          cmd_d   = bus.req_ctrl[int'(win)*WORD_WIDTH +: 2];
          addr_d  = bus.req_addr[int'(win)*WORD_WIDTH +: WORD_WIDTH];
          wdata_d = bus.req_wdata[int'(win)*WORD_WIDTH +: WORD_WIDTH];
          stat_d  = '0;
          stat_d[int'(win)*WORD_WIDTH] = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.mobo_stat[0]) begin
          ctrl_d      = '0;
          ctrl_d[1:0] = cmd_q;
          aout_d      = addr_q;
          dout_d      = (cmd_q == 2'b10) ? wdata_q : '0;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.mobo_stat[1]) begin
          ctrl_d  = '0;
          aout_d  = '0;
          dout_d  = '0;
          rdata_d = (cmd_q == 2'b01) ? bus.mobodat_in : '0;
          stat_d  = '0;
          stat_d[int'(gnt_q)*WORD_WIDTH+1] = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          // Bus never answered: abort with done+error and no data.
          ctrl_d  = '0;
          aout_d  = '0;
          dout_d  = '0;
          rdata_d = '0;
          stat_d  = '0;
          stat_d[int'(gnt_q)*WORD_WIDTH+1] = 1'b1;
          stat_d[int'(gnt_q)*WORD_WIDTH+2] = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        // Winner has released its request (00, or 11 which counts as none).
        if (!(bus.req_ctrl[int'(gnt_q)*WORD_WIDTH] ^ bus.req_ctrl[int'(gnt_q)*WORD_WIDTH+1])) begin
          stat_d  = '0;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= GW'(NUM_REQ - 1);
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      aout_q  <= '0;
      dout_q  <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      aout_q  <= aout_d;
      dout_q  <= dout_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mobo_bus_arbiter.sv
// Directed bench for mobo_bus_arbiter: write, read, contention, bus busy,
// timeout and mid-transfer reset, with hand-computed expectations.
module tb_mobo_bus_arbiter;
  localparam int W  = 32;
  localparam int N  = 2;
  localparam int TO = 255;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state;
  int         checks   = 0;
  int         failures = 0;
  logic [W-1:0] exp_q[$];

  mobo_bus_arbiter_if #(.WORD_WIDTH(W), .NUM_REQ(N)) bif();

  mobo_bus_arbiter #(.WORD_WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .state_o (state)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [1:0] cmd, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata);
    bif.req_ctrl[m*W +: W]  = W'(cmd);
    bif.req_addr[m*W +: W]  = addr;
    bif.req_wdata[m*W +: W] = wdata;
  endtask

  task automatic set_cmd(input int m, input logic [1:0] cmd);
    bif.req_ctrl[m*W +: W] = W'(cmd);
  endtask

  function automatic logic [W-1:0] stat_of(input int m);
    return bif.req_stat[m*W +: W];
  endfunction

  task automatic wait_bus(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bif.mobo_ctrl != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic         ok;
    logic [W-1:0] e;
    int           g;
    int           n;

    bif.req_ctrl   = '0;
    bif.req_addr   = '0;
    bif.req_wdata  = '0;
    bif.mobo_stat  = '0;
    bif.mobodat_in = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", 64'(state), 64'(S_IDLE));
    check_eq("rst_ctrl", 64'(bif.mobo_ctrl), 64'h0);
    check_eq("rst_addr", 64'(bif.addr_out), 64'h0);
    check_eq("rst_stat", 64'(bif.req_stat), 64'h0);
    check_eq("rst_rdata", 64'(bif.req_rdata), 64'h0);
    rst = 1'b1;
    tick();
    check_eq("idle_no_req", 64'(state), 64'(S_IDLE));

    // Single write from master 0.
    set_req(0, 2'b10, 32'h40, 32'h1234);
    tick();
    check_eq("wr_issue_state", 64'(state), 64'(S_ISSUE));
    check_eq("wr_busy", 64'(stat_of(0)), 64'h1);
    check_eq("wr_issue_ctrl", 64'(bif.mobo_ctrl), 64'h0);
    tick();
    check_eq("wr_ctrl", 64'(bif.mobo_ctrl), 64'h2);
    check_eq("wr_addr", 64'(bif.addr_out), 64'h40);
    check_eq("wr_data", 64'(bif.mobodat_out), 64'h1234);
    tick();
    tick();
    check_eq("wr_ctrl_held", 64'(bif.mobo_ctrl), 64'h2);
    bif.mobo_stat = 32'h2;
    tick();
    bif.mobo_stat = '0;
    check_eq("wr_done", 64'(stat_of(0)), 64'h2);
    check_eq("wr_ctrl_off", 64'(bif.mobo_ctrl), 64'h0);
    tick();
    check_eq("wr_resp_hold", 64'(stat_of(0)), 64'h2);
    set_cmd(0, 2'b00);
    tick();
    check_eq("wr_release", 64'(bif.req_stat), 64'h0);
    check_eq("wr_idle", 64'(state), 64'(S_IDLE));

    // Single read from master 1.
    set_req(1, 2'b01, 32'h10, 32'h5555);
    tick();
    check_eq("rd_busy", 64'(bif.req_stat), {32'h1, 32'h0});
    tick();
    check_eq("rd_ctrl", 64'(bif.mobo_ctrl), 64'h1);
    check_eq("rd_addr", 64'(bif.addr_out), 64'h10);
    check_eq("rd_wdata_zero", 64'(bif.mobodat_out), 64'h0);
    bif.mobodat_in = 32'hBEEF;
    bif.mobo_stat  = 32'h2;
    tick();
    bif.mobo_stat  = '0;
    bif.mobodat_in = '0;
    check_eq("rd_data", 64'(bif.req_rdata), 64'hBEEF);
    check_eq("rd_done", 64'(stat_of(1)), 64'h2);
    check_eq("rd_ctrl_off", 64'(bif.mobo_ctrl), 64'h0);
    set_cmd(1, 2'b00);
    tick();
    check_eq("rd_release", 64'(bif.req_stat), 64'h0);
    check_eq("rd_rdata_clr", 64'(bif.req_rdata), 64'h0);

    // Contention: both request continuously, expect 0,1,0,1.
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h200);
    set_req(0, 2'b10, 32'h100, 32'hA0);
    set_req(1, 2'b10, 32'h200, 32'hA1);
    for (int t = 0; t < 4; t++) begin
      wait_bus(10, ok);
      check_eq("ct_bus_wait", 64'(ok), 64'h1);
      e = exp_q.pop_front();
      g = (e == 32'h100) ? 0 : 1;
      check_eq("ct_grant_addr", 64'(bif.addr_out), 64'(e));
      check_eq("ct_other_idle", 64'(stat_of(1 - g)), 64'h0);
      bif.mobo_stat = 32'h2;
      tick();
      bif.mobo_stat = '0;
      check_eq("ct_done", 64'(stat_of(g)), 64'h2);
      check_eq("ct_other_zero", 64'(stat_of(1 - g)), 64'h0);
      set_cmd(g, 2'b00);
      tick();
      check_eq("ct_idle_gap", 64'(state), 64'(S_IDLE));
      check_eq("ct_stat_clr", 64'(bif.req_stat), 64'h0);
      set_cmd(g, 2'b10);
    end
    set_cmd(0, 2'b00);
    set_cmd(1, 2'b00);
    tick();
    check_eq("ct_drained", 64'(state), 64'(S_IDLE));

    // Bus busy holds the transfer in ISSUE.
    bif.mobo_stat = 32'h1;
    set_req(0, 2'b01, 32'h80, 32'h0);
    tick();
    check_eq("bb_issue", 64'(state), 64'(S_ISSUE));
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("bb_hold_state", 64'(state), 64'(S_ISSUE));
      check_eq("bb_hold_ctrl", 64'(bif.mobo_ctrl), 64'h0);
    end
    bif.mobo_stat = '0;
    tick();
    check_eq("bb_wait", 64'(state), 64'(S_WAIT));
    check_eq("bb_ctrl", 64'(bif.mobo_ctrl), 64'h1);
    check_eq("bb_addr", 64'(bif.addr_out), 64'h80);
    bif.mobodat_in = 32'hCAFE;
    bif.mobo_stat  = 32'h2;
    tick();
    bif.mobo_stat  = '0;
    bif.mobodat_in = '0;
    check_eq("bb_rdata", 64'(bif.req_rdata), 64'hCAFE);
    set_cmd(0, 2'b00);
    tick();

    // Timeout: bus never answers.
    set_req(0, 2'b01, 32'h44, 32'h0);
    tick();
    tick();
    check_eq("to_ctrl", 64'(bif.mobo_ctrl), 64'h1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (state != S_WAIT) break;
      n++;
      tick();
    end
    check_eq("to_wait_cycles", 64'(n), 64'(TO));
    check_eq("to_state", 64'(state), 64'(S_RESP));
    check_eq("to_stat", 64'(stat_of(0)), 64'h6);
    check_eq("to_rdata", 64'(bif.req_rdata), 64'h0);
    check_eq("to_ctrl_off", 64'(bif.mobo_ctrl), 64'h0);
    set_cmd(0, 2'b00);
    tick();
    check_eq("to_release", 64'(bif.req_stat), 64'h0);

    // Reset in the middle of WAIT.
    set_req(0, 2'b01, 32'h60, 32'h0);
    tick();
    tick();
    check_eq("mr_ctrl_before", 64'(bif.mobo_ctrl), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mr_ctrl_clr", 64'(bif.mobo_ctrl), 64'h0);
    check_eq("mr_stat_clr", 64'(bif.req_stat), 64'h0);
    check_eq("mr_addr_clr", 64'(bif.addr_out), 64'h0);
    check_eq("mr_state", 64'(state), 64'(S_IDLE));
    set_req(1, 2'b10, 32'h210, 32'hB1);
    set_req(0, 2'b10, 32'h110, 32'hB0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check_eq("mr_prio_m0", 64'(stat_of(0)), 64'h1);
    check_eq("mr_m1_wait", 64'(stat_of(1)), 64'h0);
    tick();
    check_eq("mr_addr_m0", 64'(bif.addr_out), 64'h110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mobo_bus_arbiter.md
Name: mobo_bus_arbiter

Overview:
- Shares the single motherboard bus (ctrl/stat/addr/data) between NUM_REQ masters, e.g. the CPU and a DMA/debug engine.
- Each master drives a private mobo-style port.
- The block grants one master at a time in round-robin order, sequences the transfer onto the bus, and returns status and read data to the winner.

Parameters:
WORD_WIDTH, 32, width of ctrl/stat/addr/data words
NUM_REQ, 2, number of requester ports (2..8)
TIMEOUT_CYC, 255, max cycles in WAIT before aborting the transfer with an error

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low: all registers cleared while rst=0
req_ctrl  in  NUM_REQ*WORD_WIDTH  per-master ctrl word; bits[1:0] cmd: 00 none, 01 read, 10 write, 11 treated as none
req_addr  in  NUM_REQ*WORD_WIDTH  per-master address
req_wdata  in  NUM_REQ*WORD_WIDTH  per-master write data
req_stat  out  NUM_REQ*WORD_WIDTH  per-master status; bit0 busy, bit1 done, bit2 error, other bits 0
req_rdata  out  WORD_WIDTH  read data, valid only to the master with done=1
mobo_ctrl  out  WORD_WIDTH  bus ctrl; bits[1:0] = granted cmd, rest 0
mobo_stat  in  WORD_WIDTH  bus status; bit0 busy, bit1 done
addr_out  out  WORD_WIDTH  bus address
mobodat_out  out  WORD_WIDTH  bus write data
mobodat_in  in  WORD_WIDTH  bus read data

Behaviour:
- All outputs are registered.
- Reset values:
  - mobo_ctrl, addr_out, mobodat_out, req_stat, req_rdata = 0.
  - State = IDLE; timeout counter = 0.
  - rr_last = NUM_REQ-1, so master 0 has first priority.
- Reset asserted mid-transfer: mobo_ctrl drops to 0 immediately (async clear). The in-flight transfer is abandoned with no done reported.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Scan masters starting at rr_last+1, wrapping modulo NUM_REQ.
  - The first master with cmd 01/10 wins.
  - At that edge: latch grant index g, cmd, addr, wdata; set rr_last=g; set req_stat[g].busy=1; go to ISSUE.
  - No valid request: stay in IDLE with all outputs 0.
- ISSUE:
  - If mobo_stat.busy=1, hold in ISSUE.
  - Else at the edge: mobo_ctrl=cmd, addr_out=addr, mobodat_out=wdata (write only, else 0); timeout counter cleared; go to WAIT.
- WAIT:
  - mobo_ctrl, addr_out and mobodat_out are held stable.
  - On an edge with mobo_stat.done=1:
    - mobo_ctrl=0.
    - If read, req_rdata=mobodat_in.
    - req_stat[g]: busy=0, done=1, error=0.
    - Go to RESP.
  - Else the counter increments. When the counter reaches TIMEOUT_CYC: mobo_ctrl=0, req_stat[g] done=1, error=1, req_rdata=0; go to RESP.
- RESP (four-phase handshake):
  - done and req_rdata are held until master g presents cmd=00.
  - At that edge: req_stat[g]=0, req_rdata=0; go to IDLE.
  - The next grant is evaluated at the following IDLE edge, giving 1 idle cycle between transfers.
- Master g changes or drops cmd during ISSUE/WAIT: ignored, because latched values are used. RESP still presents done and exits after one cycle if cmd is already 00.
- Non-granted masters:
  - Their req_stat stays 0 while waiting.
  - Their requests persist and are served in rotation order.
  - There is no starvation: max wait is NUM_REQ-1 transfers.
- Latency: request sampled at edge E0 (IDLE) → bus ctrl valid after E1 if the bus is not busy → done visible the edge after mobo_stat.done is sampled.
- Only one req_stat word is ever nonzero.
- mobo_ctrl is nonzero only in WAIT.

Test Plan:
- Single write: master 0 cmd=10, addr=0x40, wdata=0x1234; bus asserts done 3 cycles later.
  → addr_out=0x40, mobodat_out=0x1234, mobo_ctrl=2 from E1; req_stat[0]=0x2 after done; cleared after cmd=00.
- Single read: master 1 cmd=01, addr=0x10; bus returns mobodat_in=0xBEEF with done.
  → req_rdata=0xBEEF, req_stat[1]=0x2, mobo_ctrl back to 0 on the same edge.
- Contention: both masters request continuously from reset.
  → grants 0,1,0,1; each transfer separated by ≥1 IDLE cycle; req_stat never nonzero for both.
- Timeout: master 0 read, bus never asserts done, TIMEOUT_CYC=255.
  → exactly 255 WAIT cycles, then req_stat[0]=0x6, req_rdata=0, mobo_ctrl=0.
- Bus busy: mobo_stat.busy=1 for 4 cycles when master 0 requests.
  → stays in ISSUE with mobo_ctrl=0 for 4 cycles, then drives cmd.
- Reset mid-WAIT: rst=0 while mobo_ctrl=1.
  → mobo_ctrl, req_stat, addr_out all 0 immediately; after release, master 0 gets priority over a simultaneous master 1 request.
